sram_arbiter: RTL and testbench

// - Shares the single SRAM port between two requesters: port 0 = CPU datapath (MAR/MDR path), port 1 = loader/debug.
// - Sequences the active-low SRAM strobes (CE/UB/LB/OE/WE) with fixed access timing.
// - Sits between the requesters and Mem2IO/test_memory. Replaces direct ISDU strobe drive.

---
 rtl/sram_arbiter.sv | 139 +++++++++++++
 tb/tb_sram_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter for a single asynchronous SRAM port.
// All SRAM strobes and handshake outputs are registered.
module sram_arbiter #(
    parameter int ACCESS_CYCLES = 2,
    parameter int ADDR_W        = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [15:0]       wdata0,
    input  logic [15:0]       wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [15:0]       rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] A,
    output logic [15:0]       Data_to_mem,
    output logic              dout_en,
    input  logic [15:0]       Data_from_mem,
    output logic              CE_N,
    output logic              UB_N,
    output logic              LB_N,
    output logic              OE_N,
    output logic              WE_N
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES);

    if (ACCESS_CYCLES < 2 || ACCESS_CYCLES > 15) begin : g_bad_cfg
        $error("sram_arbiter: ACCESS_CYCLES must be in 2..15");
    end

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              port;
    logic              cur_we;
    logic              last;

    logic              grant_valid;
    logic              grant_port;
    logic              gnt_we;
    logic [ADDR_W-1:0] gnt_addr;
    logic [15:0]       gnt_wdata;

    // On a tie the port that did not win last time gets the SRAM.
    always_comb begin
        grant_valid = req0 | req1;
        grant_port  = 1'b0;
        if (req0 && req1)
            grant_port = !last;
        else if (req1)
            grant_port = 1'b1;
        gnt_we    = grant_port ? we1    : we0;
        gnt_addr  = grant_port ? addr1  : addr0;
        gnt_wdata = grant_port ? wdata1 : wdata0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            port        <= 1'b0;
            cur_we      <= 1'b0;
            last        <= 1'b1;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            rdata       <= 16'h0000;
            busy        <= 1'b0;
            A           <= '0;
            Data_to_mem <= 16'h0000;
            dout_en     <= 1'b0;
            CE_N        <= 1'b1;
            UB_N        <= 1'b1;
            LB_N        <= 1'b1;
            OE_N        <= 1'b1;
            WE_N        <= 1'b1;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        state   <= ACCESS;
                        cnt     <= 4'd1;
                        port    <= grant_port;
                        cur_we  <= gnt_we;
                        last    <= grant_port;
                        A       <= gnt_addr;
                        if (gnt_we)
                            Data_to_mem <= gnt_wdata;
                        dout_en <= gnt_we;
                        busy    <= 1'b1;
                        CE_N    <= 1'b0;
                        UB_N    <= 1'b0;
                        LB_N    <= 1'b0;
                        OE_N    <= gnt_we;
                        WE_N    <= 1'b1;
                    end
                end
                ACCESS: begin
                    // The first access cycle is address setup, so WE_N only falls from cycle 2.
                    if (cnt == LAST_CNT) begin
                        state <= DONE;
                        OE_N  <= 1'b1;
                        WE_N  <= 1'b1;
                        if (!cur_we)
                            rdata <= Data_from_mem;
                        ack0  <= !port;
                        ack1  <= port;
                    end else begin
                        cnt  <= cnt + 4'd1;
                        WE_N <= !cur_we;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    dout_en <= 1'b0;
                    CE_N    <= 1'b1;
                    UB_N    <= 1'b1;
                    LB_N    <= 1'b1;
                    OE_N    <= 1'b1;
                    WE_N    <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: one instance with 2 access cycles, one with 5,
// each attached to a small behavioural SRAM.
module tb_sram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        Reset;
    logic        req0, req1, we0, we1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, busy, dout_en;
    logic [15:0] rdata, A, Data_to_mem, Data_from_mem;
    logic        CE_N, UB_N, LB_N, OE_N, WE_N;

    logic        s_req0, s_req1, s_we0, s_we1;
    logic [15:0] s_addr0, s_addr1, s_wdata0, s_wdata1;
    logic        s_ack0, s_ack1, s_busy, s_dout_en;
    logic [15:0] s_rdata, s_A, s_Data_to_mem, s_Data_from_mem;
    logic        s_CE_N, s_UB_N, s_LB_N, s_OE_N, s_WE_N;

    logic [15:0] mem2 [0:255];
    logic [15:0] mem5 [0:255];

    int total = 0;
    int bad   = 0;
    int seen;

    sram_arbiter #(.ACCESS_CYCLES(2), .ADDR_W(16)) dut (
        .Clk(clk), .Reset(Reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
        .A(A), .Data_to_mem(Data_to_mem), .dout_en(dout_en),
        .Data_from_mem(Data_from_mem),
        .CE_N(CE_N), .UB_N(UB_N), .LB_N(LB_N), .OE_N(OE_N), .WE_N(WE_N)
    );

    sram_arbiter #(.ACCESS_CYCLES(5), .ADDR_W(16)) dut5 (
        .Clk(clk), .Reset(Reset),
        .req0(s_req0), .req1(s_req1), .we0(s_we0), .we1(s_we1),
        .addr0(s_addr0), .addr1(s_addr1), .wdata0(s_wdata0), .wdata1(s_wdata1),
        .ack0(s_ack0), .ack1(s_ack1), .rdata(s_rdata), .busy(s_busy),
        .A(s_A), .Data_to_mem(s_Data_to_mem), .dout_en(s_dout_en),
        .Data_from_mem(s_Data_from_mem),
        .CE_N(s_CE_N), .UB_N(s_UB_N), .LB_N(s_LB_N), .OE_N(s_OE_N), .WE_N(s_WE_N)
    );

    // Behavioural SRAMs; reset preloads the word the read tests expect.
    assign Data_from_mem   = OE_N   ? 16'hDEAD : mem2[A[7:0]];
    assign s_Data_from_mem = s_OE_N ? 16'hDEAD : mem5[s_A[7:0]];

    always @(posedge clk) begin
        if (Reset) begin
            mem2[8'h10] <= 16'h1234;
            mem5[8'h10] <= 16'h5A5A;
        end else begin
            if (!CE_N && !WE_N)
                mem2[A[7:0]] <= Data_to_mem;
            if (!s_CE_N && !s_WE_N)
                mem5[s_A[7:0]] <= s_Data_to_mem;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        Reset = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        s_req0 = 0; s_req1 = 0; s_we0 = 0; s_we1 = 0;
        s_addr0 = 0; s_addr1 = 0; s_wdata0 = 0; s_wdata1 = 0;
        tick(); tick();

        check_output("rst_ce", CE_N, 1);
        check_output("rst_oe", OE_N, 1);
        check_output("rst_we", WE_N, 1);
        check_output("rst_den", dout_en, 0);
        check_output("rst_ack", {ack0, ack1}, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_a", A, 0);
        check_output("rst_rdata", rdata, 0);
        check_output("rst_dtm", Data_to_mem, 0);
        check_output("rst5_busy", s_busy, 0);
        Reset = 1'b0;

        // CPU read of 0x10
        req0 = 1; we0 = 0; addr0 = 16'h0010;
        tick();
        check_output("rd_c1_oe", OE_N, 0);
        check_output("rd_c1_we", WE_N, 1);
        check_output("rd_c1_ce", CE_N, 0);
        check_output("rd_c1_a", A, 16'h0010);
        check_output("rd_c1_busy", busy, 1);
        check_output("rd_c1_ack", ack0, 0);
        tick();
        check_output("rd_c2_oe", OE_N, 0);
        check_output("rd_c2_ack", ack0, 0);
        tick();
        check_output("rd_ack0", ack0, 1);
        check_output("rd_ack1", ack1, 0);
        check_output("rd_data", rdata, 16'h1234);
        check_output("rd_done_oe", OE_N, 1);
        check_output("rd_done_ce", CE_N, 0);
        req0 = 0;
        tick();
        check_output("rd_idle_ack", ack0, 0);
        check_output("rd_idle_ce", CE_N, 1);
        check_output("rd_idle_busy", busy, 0);
        check_output("rd_idle_rdata", rdata, 16'h1234);
        check_output("rd_idle_a", A, 16'h0010);

        // Loader write of BEEF to 0x20
        req1 = 1; we1 = 1; addr1 = 16'h0020; wdata1 = 16'hBEEF;
        tick();
        check_output("wr_c1_we", WE_N, 1);
        check_output("wr_c1_oe", OE_N, 1);
        check_output("wr_c1_den", dout_en, 1);
        check_output("wr_c1_dtm", Data_to_mem, 16'hBEEF);
        check_output("wr_c1_a", A, 16'h0020);
        tick();
        check_output("wr_c2_we", WE_N, 0);
        check_output("wr_c2_den", dout_en, 1);
        tick();
        check_output("wr_done_we", WE_N, 1);
        check_output("wr_done_den", dout_en, 1);
        check_output("wr_ack1", ack1, 1);
        check_output("wr_ack0", ack0, 0);
        req1 = 0;
        tick();
        check_output("wr_mem", mem2[8'h20], 16'hBEEF);
        check_output("wr_idle_den", dout_en, 0);

        // Port 1 requests while port 0 is mid-access
        req0 = 1; we0 = 0; addr0 = 16'h0010;
        tick();
        req1 = 1; we1 = 1; addr1 = 16'h0030; wdata1 = 16'hCAFE;
        tick();
        check_output("late_c2_a", A, 16'h0010);
        check_output("late_c2_oe", OE_N, 0);
        check_output("late_c2_den", dout_en, 0);
        tick();
        check_output("late_ack0", ack0, 1);
        check_output("late_ack1", ack1, 0);
        check_output("late_rdata", rdata, 16'h1234);
        req0 = 0;
        tick();
        check_output("late_idle_ce", CE_N, 1);
        tick();
        check_output("late_p1_a", A, 16'h0030);
        check_output("late_p1_den", dout_en, 1);
        tick(); tick();
        check_output("late_p1_ack", ack1, 1);
        req1 = 0;
        tick();
        check_output("late_mem", mem2[8'h30], 16'hCAFE);

        // Reset held 3 cycles in the middle of a port-0 write
        req0 = 1; we0 = 1; addr0 = 16'h0040; wdata0 = 16'h1111;
        tick(); tick();
        check_output("mid_c2_we", WE_N, 0);
        Reset = 1; req0 = 0;
        tick();
        check_output("mid_ce", CE_N, 1);
        check_output("mid_we", WE_N, 1);
        check_output("mid_oe", OE_N, 1);
        check_output("mid_den", dout_en, 0);
        check_output("mid_ack", {ack0, ack1}, 0);
        check_output("mid_busy", busy, 0);
        tick(); tick();
        Reset = 0;
        tick();
        check_output("mid_idle_ce", CE_N, 1);
        check_output("mid_idle_ack", {ack0, ack1}, 0);

        // Both ports held high: grants alternate starting with port 0
        req0 = 1; we0 = 0; addr0 = 16'h0010;
        req1 = 1; we1 = 0; addr1 = 16'h0020;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_output("tie_c1_noack", {ack0, ack1}, 0);
            tick();
            tick();
            check_output("tie_ack0", ack0, (k % 2 == 0) ? 1 : 0);
            check_output("tie_ack1", ack1, (k % 2 == 1) ? 1 : 0);
            check_output("tie_rdata", rdata, (k % 2 == 0) ? 16'h1234 : 16'hBEEF);
            if (k == 3) begin
                req0 = 0;
                req1 = 0;
            end
            tick();
            check_output("tie_idle_noack", {ack0, ack1}, 0);
        end

        // ACCESS_CYCLES=5 read: ack after 6 cycles
        s_req0 = 1; s_we0 = 0; s_addr0 = 16'h0010;
        seen = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check_output("s5_rd_excl", s_WE_N | s_OE_N, 1);
            if (i <= 5)
                check_output("s5_rd_oe", s_OE_N, 0);
            if (s_ack0) begin
                seen = i;
                break;
            end
        end
        check_output("s5_rd_lat", seen, 6);
        check_output("s5_rd_data", s_rdata, 16'h5A5A);
        s_req0 = 0;
        tick();

        // ACCESS_CYCLES=5 write: WE_N low in cycles 2..5 only
        s_req1 = 1; s_we1 = 1; s_addr1 = 16'h0022; s_wdata1 = 16'h7777;
        seen = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check_output("s5_wr_excl", s_WE_N | s_OE_N, 1);
            if (i <= 5)
                check_output("s5_wr_we", s_WE_N, (i >= 2) ? 0 : 1);
            if (s_ack1) begin
                seen = i;
                break;
            end
        end
        check_output("s5_wr_lat", seen, 6);
        check_output("s5_wr_den", s_dout_en, 1);
        s_req1 = 0;
        tick();
        check_output("s5_wr_mem", mem5[8'h22], 16'h7777);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
